execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 16-bit pipelined processor. It takes decoded ID/EX fields, performs ALU, I/O, stack-address and branch-condition work combinationally, and registers results into the EX/MEM pipeline register and the architectural flag register (NF|CF|ZF). It sits between the ID/EX buffer and the memory stage.

## Interface
- No parameters. Flag vector order everywhere: [2]=NF, [1]=CF, [0]=ZF.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears EX/MEM register and flags.
- `IOR, IOW, OPS, ALU, MR, MW, WB, JMP, SP, SPOP, JWSP, IMM, Stack_PC, Stack_Flags`  in  1 each  decoded controls.
- `FD`  in  2  flag mode.
- `FGS`  in  2  jump-condition select.
- `ALU_OP, WB_Address, SRC_Address`  in  3 each  ALU operation and register addresses.
- `Data1, Data2, Immediate_Value`  in  16 each  operands.
- `PC, Stack_Pointer`  in  32 each  program counter and stack pointer.
- `Forwarding_Unit_Selectors`  in  2  bit0 selects forwarded operand 1; bit1 selects forwarded operand 2.
- `Data_From_Forwarding_Unit1/2`  in  16 each  forwarded operands.
- `Flags_From_Memory`  in  3  popped flags.
- `INPUT_PORT`  in  16.
- `OUTPUT_PORT_Input`  in  16  current output-port register value.
- `OUTPUT_PORT`  out  16  next output-port value (combinational).
- `Stack_Pointer_Out`  out  32  updated SP (combinational).
- `Taken_Jump, To_PC_Selector`  out  1 each  combinational.
- `Flags`  out  3  flag register.
- `EXMEM`  out  76  registered buffer: Data[31:0], WB_Address[34:32], MR[35], MW[36], WB[37], Address[69:38], JWSP[70], Stack_PC[71], Stack_Flags[72], Final_Flags[75:73].

## Operation
- Operands: A = sel0 ? Fwd1 : Data1; B = IMM ? Immediate_Value : (sel1 ? Fwd2 : Data2).
- ALU=1 result R by ALU_OP:
  - 0: OPS ? A+1 : A+B.
  - 1: OPS ? A−1 : A−B.
  - 2: A&B.
  - 3: A|B.
  - 4: A<<B.
  - 5: A>>B (logical).
  - 6: R=A.
  - 7: ~A.
- ALU=0: R = IOR ? INPUT_PORT : B (MOV).
- ALU carry:
  - Add/inc: bit 16 of the 17-bit sum.
  - Sub/dec: borrow (unsigned A < subtrahend).
  - Shift by n, 1≤n≤16: SHL CF=A[16−n]; SHR CF=A[n−1].
  - Shift n=0 or AND/OR/NOT/pass: CF unchanged.
  - Shift n>16: R=0, CF=0.
- FD: 00 CF←0, NF/ZF held; 01 CF←1, NF/ZF held; 10 all held; 11 NF=R[15], ZF=(R==0), CF per ALU rule.
- Flag override: Stack_Flags & SPOP → Final_Flags = Flags_From_Memory, overriding FD.
- OUTPUT_PORT = IOW ? A : OUTPUT_PORT_Input.
- Stack (SP=1):
  - Step is 2 if Stack_PC, else 1.
  - Push (SPOP=0): Address = Stack_Pointer; Stack_Pointer_Out = SP − step.
  - Pop (SPOP=1): Stack_Pointer_Out = SP + step; Address = Stack_Pointer_Out.
  - SP=0: Stack_Pointer_Out = Stack_Pointer; Address = {16'b0, B}.
- Data = Stack_PC & !SPOP ? PC : {16'b0, R}.
- Jumps:
  - Condition by FGS: 00 ZF, 01 NF, 10 CF, 11 always.
  - Taken_Jump = JMP & condition, evaluated on the Flags register.
  - To_PC_Selector = Taken_Jump | (JWSP & SPOP).
- MR, MW, WB, WB_Address, JWSP, Stack_PC, Stack_Flags pass through unchanged.

## Timing
- The execute path is combinational; EX/MEM and Flags load Final_Flags on the rising clk edge.
- Latency: one cycle. An instruction's result appears on EXMEM and Flags at the edge after its inputs are applied.
- Reset (async): EXMEM=0 and Flags=000 immediately and while asserted.
- Reset deasserted mid-stream: the first edge after release loads normally.
- Forward/immediate priority: IMM over forwarding for B.
- A pop of flags and FD=11 in the same op: the pop wins.

## Structure
- Shared package: ALU_OP codes, FD codes, FGS codes, EX/MEM field offsets/width (76), flag bit indices.
- Natural sub-module: `alu16` (R, NF, ZF, CF, carry-valid).
- The register logic (EX/MEM and flags) is inline.

## Test plan
- Reset, then MOV, FD=10, Data2=127 → Data=127, WB_Address=111, Flags=000.
- ADD 7+8 FD=11 → Data=15, Flags=000; SUB 23−8 → 15, 000; SUB 8−23 → 0xFFF1, Flags=110.
- AND 5&10 → 0, Flags=001; OR → 15, Flags=000.
- IMM=1 shifts on A=0xFFFF:
  - SHL 16 → 0, Flags=011.
  - SHR 16 → 0, Flags=011.
  - SHL 15 → 0x8000, Flags=110.
  - SHR 15 → 1, Flags=010.
- INC 7 → 8; DEC 7 → 6; NOT 15 → 0xFFF0, Flags NF=1, CF held.
- Flag mode, I/O and forwarding:
  - SETC → CF=1; CLRC → CF=0.
  - IN with INPUT_PORT=12 → Data=12.
  - OUT A=77 → OUTPUT_PORT=77.
  - Forwarding sel=01, Fwd1=55, ADD B=0 → 55.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// +------------------------------------------------------------------+
// | execute_stage_pkg : shared codes and EX/MEM layout for execute    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package execute_stage_pkg;

  typedef enum logic [2:0] {
    c_op_add  = 3'd0,
    c_op_sub  = 3'd1,
    c_op_and  = 3'd2,
    c_op_or   = 3'd3,
    c_op_shl  = 3'd4,
    c_op_shr  = 3'd5,
    c_op_pass = 3'd6,
    c_op_not  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    c_fd_clrc   = 2'b00,
    c_fd_setc   = 2'b01,
    c_fd_hold   = 2'b10,
    c_fd_update = 2'b11
  } fd_t;

  typedef enum logic [1:0] {
    c_fgs_zf     = 2'b00,
    c_fgs_nf     = 2'b01,
    c_fgs_cf     = 2'b10,
    c_fgs_always = 2'b11
  } fgs_t;

  localparam int c_exmem_width     = 76;
  localparam int c_data_lsb        = 0;
  localparam int c_wb_addr_lsb     = 32;
  localparam int c_mr_bit          = 35;
  localparam int c_mw_bit          = 36;
  localparam int c_wb_bit          = 37;
  localparam int c_addr_lsb        = 38;
  localparam int c_jwsp_bit        = 70;
  localparam int c_stack_pc_bit    = 71;
  localparam int c_stack_flags_bit = 72;
  localparam int c_flags_lsb       = 73;

  localparam int c_flag_nf = 2;
  localparam int c_flag_cf = 1;
  localparam int c_flag_zf = 0;

endpackage

`default_nettype wire

// File: rtl/execute_stage_alu.sv
// +------------------------------------------------------------------+
// | alu16 : 16-bit ALU with carry and carry-valid indication          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module alu16
  import execute_stage_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [2:0]  i_alu_op,
  input  logic        i_ops,
  output logic [15:0] o_r,
  output logic        o_cf,
  output logic        o_cf_valid
);

  logic [15:0] w_operand;
  logic [16:0] w_sum;
  logic [16:0] w_diff;
  logic [16:0] w_shl;
  logic [16:0] w_shr;
  logic        w_shift_zero;
  logic        w_shift_big;

  assign w_operand    = i_ops ? 16'd1 : i_b;
  assign w_sum        = {1'b0, i_a} + {1'b0, w_operand};
  assign w_diff       = {1'b0, i_a} - {1'b0, w_operand};
  // One guard bit beside the operand catches the last bit shifted out.
  assign w_shl        = {1'b0, i_a} << i_b[4:0];
  assign w_shr        = {i_a, 1'b0} >> i_b[4:0];
  assign w_shift_zero = (i_b == 16'd0);
  assign w_shift_big  = (i_b > 16'd16);

  always_comb begin
    o_r        = i_a;
    o_cf       = 1'b0;
    o_cf_valid = 1'b0;
    case (i_alu_op)
      c_op_add: begin
        o_r        = w_sum[15:0];
        o_cf       = w_sum[16];
        o_cf_valid = 1'b1;
      end
      c_op_sub: begin
        o_r        = w_diff[15:0];
        o_cf       = w_diff[16];
        o_cf_valid = 1'b1;
      end
      c_op_and: o_r = i_a & i_b;
      c_op_or:  o_r = i_a | i_b;
      c_op_shl: begin
        if (w_shift_big) begin
          o_r        = 16'd0;
          o_cf_valid = 1'b1;
        end else if (!w_shift_zero) begin
          o_r        = w_shl[15:0];
          o_cf       = w_shl[16];
          o_cf_valid = 1'b1;
        end
      end
      c_op_shr: begin
        if (w_shift_big) begin
          o_r        = 16'd0;
          o_cf_valid = 1'b1;
        end else if (!w_shift_zero) begin
          o_r        = w_shr[16:1];
          o_cf       = w_shr[0];
          o_cf_valid = 1'b1;
        end
      end
      c_op_pass: o_r = i_a;
      c_op_not:  o_r = ~i_a;
      default:   o_r = i_a;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// +------------------------------------------------------------------+
// | execute_stage : ALU/IO/stack/branch work and EX/MEM + flag regs   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        IOR,
  input  logic        IOW,
  input  logic        OPS,
  input  logic        ALU,
  input  logic        MR,
  input  logic        MW,
  input  logic        WB,
  input  logic        JMP,
  input  logic        SP,
  input  logic        SPOP,
  input  logic        JWSP,
  input  logic        IMM,
  input  logic        Stack_PC,
  input  logic        Stack_Flags,
  input  logic [1:0]  FD,
  input  logic [1:0]  FGS,
  input  logic [2:0]  ALU_OP,
  input  logic [2:0]  WB_Address,
  input  logic [2:0]  SRC_Address,
  input  logic [15:0] Data1,
  input  logic [15:0] Data2,
  input  logic [15:0] Immediate_Value,
  input  logic [31:0] PC,
  input  logic [31:0] Stack_Pointer,
  input  logic [1:0]  Forwarding_Unit_Selectors,
  input  logic [15:0] Data_From_Forwarding_Unit1,
  input  logic [15:0] Data_From_Forwarding_Unit2,
  input  logic [2:0]  Flags_From_Memory,
  input  logic [15:0] INPUT_PORT,
  input  logic [15:0] OUTPUT_PORT_Input,
  output logic [15:0] OUTPUT_PORT,
  output logic [31:0] Stack_Pointer_Out,
  output logic        Taken_Jump,
  output logic        To_PC_Selector,
  output logic [2:0]  Flags,
  output logic [75:0] EXMEM
);

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_alu_r;
  logic        w_alu_cf;
  logic        w_alu_cf_valid;
  logic [15:0] w_result;
  logic        w_carry_live;
  logic [31:0] w_step;
  logic [31:0] w_address;
  logic [31:0] w_data;
  logic [2:0]  w_final_flags;
  logic        w_condition;
  logic [c_exmem_width-1:0] w_exmem_next;
  logic        w_unused_src;

  logic [c_exmem_width-1:0] r_exmem;
  logic [2:0]               r_flags;

  // Source register address is consumed by forwarding/hazard logic upstream.
  assign w_unused_src = ^SRC_Address;

  assign w_a = Forwarding_Unit_Selectors[0] ? Data_From_Forwarding_Unit1 : Data1;
  assign w_b = IMM ? Immediate_Value
                   : (Forwarding_Unit_Selectors[1] ? Data_From_Forwarding_Unit2 : Data2);

  alu16 u_alu (
    .i_a        (w_a),
    .i_b        (w_b),
    .i_alu_op   (ALU_OP),
    .i_ops      (OPS),
    .o_r        (w_alu_r),
    .o_cf       (w_alu_cf),
    .o_cf_valid (w_alu_cf_valid)
  );

  assign w_result     = ALU ? w_alu_r : (IOR ? INPUT_PORT : w_b);
  assign w_carry_live = ALU & w_alu_cf_valid;
  assign OUTPUT_PORT  = IOW ? w_a : OUTPUT_PORT_Input;

  assign w_step = Stack_PC ? 32'd2 : 32'd1;

  always_comb begin
    Stack_Pointer_Out = Stack_Pointer;
    w_address         = {16'b0, w_b};
    if (SP) begin
      if (SPOP) begin
        Stack_Pointer_Out = Stack_Pointer + w_step;
        w_address         = Stack_Pointer + w_step;
      end else begin
        Stack_Pointer_Out = Stack_Pointer - w_step;
        w_address         = Stack_Pointer;
      end
    end
  end

  assign w_data = (Stack_PC && !SPOP) ? PC : {16'b0, w_result};

  // A flag pop restores saved flags and takes precedence over any FD mode.
  always_comb begin
    w_final_flags = r_flags;
    if (Stack_Flags && SPOP) begin
      w_final_flags = Flags_From_Memory;
    end else begin
      case (FD)
        c_fd_clrc: w_final_flags[c_flag_cf] = 1'b0;
        c_fd_setc: w_final_flags[c_flag_cf] = 1'b1;
        c_fd_hold: w_final_flags = r_flags;
        c_fd_update: begin
          w_final_flags[c_flag_nf] = w_result[15];
          w_final_flags[c_flag_zf] = (w_result == 16'd0);
          if (w_carry_live) begin
            w_final_flags[c_flag_cf] = w_alu_cf;
          end
        end
        default: w_final_flags = r_flags;
      endcase
    end
  end

  always_comb begin
    w_exmem_next                          = '0;
    w_exmem_next[c_data_lsb +: 32]        = w_data;
    w_exmem_next[c_wb_addr_lsb +: 3]      = WB_Address;
    w_exmem_next[c_mr_bit]                = MR;
    w_exmem_next[c_mw_bit]                = MW;
    w_exmem_next[c_wb_bit]                = WB;
    w_exmem_next[c_addr_lsb +: 32]        = w_address;
    w_exmem_next[c_jwsp_bit]              = JWSP;
    w_exmem_next[c_stack_pc_bit]          = Stack_PC;
    w_exmem_next[c_stack_flags_bit]       = Stack_Flags;
    w_exmem_next[c_flags_lsb +: 3]        = w_final_flags;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exmem <= '0;
      r_flags <= 3'b000;
    end else begin
      r_exmem <= w_exmem_next;
      r_flags <= w_final_flags;
    end
  end

  // Branch condition looks at the architectural flags, not this op's result.
  always_comb begin
    case (FGS)
      c_fgs_zf:     w_condition = r_flags[c_flag_zf];
      c_fgs_nf:     w_condition = r_flags[c_flag_nf];
      c_fgs_cf:     w_condition = r_flags[c_flag_cf];
      c_fgs_always: w_condition = 1'b1;
      default:      w_condition = 1'b1;
    endcase
  end

  assign Taken_Jump     = JMP & w_condition;
  assign To_PC_Selector = Taken_Jump | (JWSP & SPOP);

  assign Flags = r_flags;
  assign EXMEM = r_exmem;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// +------------------------------------------------------------------+
// | tb_execute_stage : directed self-checking bench for execute_stage |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_execute_stage;

  logic        clk, reset;
  logic        IOR, IOW, OPS, ALU, MR, MW, WB, JMP, SP, SPOP, JWSP, IMM, Stack_PC, Stack_Flags;
  logic [1:0]  FD, FGS, Forwarding_Unit_Selectors;
  logic [2:0]  ALU_OP, WB_Address, SRC_Address, Flags_From_Memory;
  logic [15:0] Data1, Data2, Immediate_Value, Data_From_Forwarding_Unit1, Data_From_Forwarding_Unit2;
  logic [15:0] INPUT_PORT, OUTPUT_PORT_Input, OUTPUT_PORT;
  logic [31:0] PC, Stack_Pointer, Stack_Pointer_Out;
  logic        Taken_Jump, To_PC_Selector;
  logic [2:0]  Flags;
  logic [75:0] EXMEM;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk(clk), .reset(reset),
    .IOR(IOR), .IOW(IOW), .OPS(OPS), .ALU(ALU), .MR(MR), .MW(MW), .WB(WB),
    .JMP(JMP), .SP(SP), .SPOP(SPOP), .JWSP(JWSP), .IMM(IMM),
    .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags),
    .FD(FD), .FGS(FGS), .ALU_OP(ALU_OP), .WB_Address(WB_Address), .SRC_Address(SRC_Address),
    .Data1(Data1), .Data2(Data2), .Immediate_Value(Immediate_Value),
    .PC(PC), .Stack_Pointer(Stack_Pointer),
    .Forwarding_Unit_Selectors(Forwarding_Unit_Selectors),
    .Data_From_Forwarding_Unit1(Data_From_Forwarding_Unit1),
    .Data_From_Forwarding_Unit2(Data_From_Forwarding_Unit2),
    .Flags_From_Memory(Flags_From_Memory),
    .INPUT_PORT(INPUT_PORT), .OUTPUT_PORT_Input(OUTPUT_PORT_Input),
    .OUTPUT_PORT(OUTPUT_PORT), .Stack_Pointer_Out(Stack_Pointer_Out),
    .Taken_Jump(Taken_Jump), .To_PC_Selector(To_PC_Selector),
    .Flags(Flags), .EXMEM(EXMEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    {IOR, IOW, OPS, ALU, MR, MW, WB, JMP, SP, SPOP, JWSP, IMM, Stack_PC, Stack_Flags} = '0;
    FD = 2'b10; FGS = 2'b00; Forwarding_Unit_Selectors = 2'b00;
    ALU_OP = 3'd0; WB_Address = 3'd0; SRC_Address = 3'd0; Flags_From_Memory = 3'd0;
    Data1 = 16'd0; Data2 = 16'd0; Immediate_Value = 16'd0;
    Data_From_Forwarding_Unit1 = 16'd0; Data_From_Forwarding_Unit2 = 16'd0;
    INPUT_PORT = 16'd0; OUTPUT_PORT_Input = 16'd0; PC = 32'd0; Stack_Pointer = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input logic [2:0] op, input logic ops, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] fd);
    clear_inputs();
    ALU = 1'b1; ALU_OP = op; OPS = ops; Data1 = a; Data2 = b; FD = fd;
    step();
  endtask

  task automatic run_shift(input logic [2:0] op, input logic [15:0] n);
    clear_inputs();
    ALU = 1'b1; ALU_OP = op; Data1 = 16'hFFFF; IMM = 1'b1; Immediate_Value = n; FD = 2'b11;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #3;
    checks++;
    if (EXMEM !== 76'd0) begin errors++; $display("FAIL reset_exmem got %h exp 0", EXMEM); end
    checks++;
    if (Flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", Flags); end
    #4 reset = 1'b0;
  endtask

  task automatic test_mov();
    clear_inputs();
    Data2 = 16'd127; WB_Address = 3'b111; WB = 1'b1; FD = 2'b10;
    step();
    checks++;
    if (EXMEM[31:0] !== 32'd127) begin errors++; $display("FAIL mov_data got %h exp 127", EXMEM[31:0]); end
    checks++;
    if (EXMEM[37:32] !== 6'b100111) begin errors++; $display("FAIL mov_ctrl got %b exp 100111", EXMEM[37:32]); end
    checks++;
    if (Flags !== 3'b000) begin errors++; $display("FAIL mov_flags got %b exp 000", Flags); end
  endtask

  task automatic test_arith();
    run_alu(3'd0, 1'b0, 16'd7, 16'd8, 2'b11);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'd15, 3'b000}) begin errors++; $display("FAIL add got %h/%b exp 000f/000", EXMEM[15:0], Flags); end
    run_alu(3'd1, 1'b0, 16'd23, 16'd8, 2'b11);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'd15, 3'b000}) begin errors++; $display("FAIL sub got %h/%b exp 000f/000", EXMEM[15:0], Flags); end
    run_alu(3'd1, 1'b0, 16'd8, 16'd23, 2'b11);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'hFFF1, 3'b110}) begin errors++; $display("FAIL sub_borrow got %h/%b exp fff1/110", EXMEM[15:0], Flags); end
    checks++;
    if (EXMEM[75:73] !== 3'b110) begin errors++; $display("FAIL exmem_flags got %b exp 110", EXMEM[75:73]); end
  endtask

  task automatic test_logic();
    run_alu(3'd6, 1'b0, 16'd0, 16'd0, 2'b00);
    checks++;
    if (Flags !== 3'b100) begin errors++; $display("FAIL clrc_hold got %b exp 100", Flags); end
    run_alu(3'd2, 1'b0, 16'd5, 16'd10, 2'b11);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'd0, 3'b001}) begin errors++; $display("FAIL and got %h/%b exp 0000/001", EXMEM[15:0], Flags); end
    run_alu(3'd3, 1'b0, 16'd5, 16'd10, 2'b11);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'd15, 3'b000}) begin errors++; $display("FAIL or got %h/%b exp 000f/000", EXMEM[15:0], Flags); end
  endtask

  task automatic test_shift();
    run_shift(3'd4, 16'd16);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'd0, 3'b011}) begin errors++; $display("FAIL shl16 got %h/%b exp 0000/011", EXMEM[15:0], Flags); end
    run_shift(3'd5, 16'd16);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'd0, 3'b011}) begin errors++; $display("FAIL shr16 got %h/%b exp 0000/011", EXMEM[15:0], Flags); end
    run_shift(3'd4, 16'd15);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'h8000, 3'b110}) begin errors++; $display("FAIL shl15 got %h/%b exp 8000/110", EXMEM[15:0], Flags); end
    run_shift(3'd5, 16'd15);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'h0001, 3'b010}) begin errors++; $display("FAIL shr15 got %h/%b exp 0001/010", EXMEM[15:0], Flags); end
    run_shift(3'd4, 16'd0);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'hFFFF, 3'b110}) begin errors++; $display("FAIL shl0 got %h/%b exp ffff/110", EXMEM[15:0], Flags); end
    run_shift(3'd4, 16'd17);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'd0, 3'b001}) begin errors++; $display("FAIL shl17 got %h/%b exp 0000/001", EXMEM[15:0], Flags); end
  endtask

  task automatic test_incdec_not();
    run_alu(3'd0, 1'b1, 16'd7, 16'd100, 2'b11);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'd8, 3'b000}) begin errors++; $display("FAIL inc got %h/%b exp 0008/000", EXMEM[15:0], Flags); end
    run_alu(3'd1, 1'b1, 16'd7, 16'd100, 2'b11);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'd6, 3'b000}) begin errors++; $display("FAIL dec got %h/%b exp 0006/000", EXMEM[15:0], Flags); end
    run_alu(3'd6, 1'b0, 16'd0, 16'd0, 2'b01);
    checks++;
    if (Flags !== 3'b010) begin errors++; $display("FAIL setc got %b exp 010", Flags); end
    run_alu(3'd7, 1'b0, 16'd15, 16'd0, 2'b11);
    checks++;
    if ({EXMEM[15:0], Flags} !== {16'hFFF0, 3'b110}) begin errors++; $display("FAIL not got %h/%b exp fff0/110", EXMEM[15:0], Flags); end
    run_alu(3'd6, 1'b0, 16'd0, 16'd0, 2'b00);
    checks++;
    if (Flags !== 3'b100) begin errors++; $display("FAIL clrc got %b exp 100", Flags); end
  endtask

  task automatic test_io();
    clear_inputs();
    IOR = 1'b1; INPUT_PORT = 16'd12; Data2 = 16'd99;
    step();
    checks++;
    if (EXMEM[31:0] !== 32'd12) begin errors++; $display("FAIL in got %h exp 12", EXMEM[31:0]); end
    clear_inputs();
    IOW = 1'b1; Data1 = 16'd77; OUTPUT_PORT_Input = 16'd5;
    #1;
    checks++;
    if (OUTPUT_PORT !== 16'd77) begin errors++; $display("FAIL out got %0d exp 77", OUTPUT_PORT); end
    IOW = 1'b0;
    #1;
    checks++;
    if (OUTPUT_PORT !== 16'd5) begin errors++; $display("FAIL out_hold got %0d exp 5", OUTPUT_PORT); end
  endtask

  task automatic test_forwarding();
    run_alu(3'd0, 1'b0, 16'd999, 16'd0, 2'b10);
    Forwarding_Unit_Selectors = 2'b01; Data_From_Forwarding_Unit1 = 16'd55;
    step();
    checks++;
    if (EXMEM[15:0] !== 16'd55) begin errors++; $display("FAIL fwd1 got %0d exp 55", EXMEM[15:0]); end
    clear_inputs();
    ALU = 1'b1; Data1 = 16'd10; Data2 = 16'd100; Forwarding_Unit_Selectors = 2'b10;
    Data_From_Forwarding_Unit2 = 16'd3; IMM = 1'b1; Immediate_Value = 16'd4;
    step();
    checks++;
    if (EXMEM[15:0] !== 16'd14) begin errors++; $display("FAIL imm_priority got %0d exp 14", EXMEM[15:0]); end
    IMM = 1'b0;
    step();
    checks++;
    if (EXMEM[15:0] !== 16'd13) begin errors++; $display("FAIL fwd2 got %0d exp 13", EXMEM[15:0]); end
  endtask

  task automatic test_stack();
    clear_inputs();
    SP = 1'b1; Stack_PC = 1'b1; Stack_Pointer = 32'd100; PC = 32'h12345678;
    #1;
    checks++;
    if (Stack_Pointer_Out !== 32'd98) begin errors++; $display("FAIL push_sp got %0d exp 98", Stack_Pointer_Out); end
    step();
    checks++;
    if ({EXMEM[69:38], EXMEM[31:0]} !== {32'd100, 32'h12345678}) begin errors++; $display("FAIL push got %h/%h exp 100/12345678", EXMEM[69:38], EXMEM[31:0]); end
    Stack_PC = 1'b0; SPOP = 1'b1;
    step();
    checks++;
    if ({Stack_Pointer_Out, EXMEM[69:38]} !== {32'd101, 32'd101}) begin errors++; $display("FAIL pop got %0d/%0d exp 101/101", Stack_Pointer_Out, EXMEM[69:38]); end
    clear_inputs();
    Stack_Pointer = 32'd200; Data2 = 16'h1234;
    step();
    checks++;
    if ({Stack_Pointer_Out, EXMEM[69:38]} !== {32'd200, 32'h1234}) begin errors++; $display("FAIL no_sp got %h/%h exp c8/1234", Stack_Pointer_Out, EXMEM[69:38]); end
  endtask

  task automatic test_flag_pop();
    clear_inputs();
    ALU = 1'b1; FD = 2'b11; SP = 1'b1; SPOP = 1'b1; Stack_Flags = 1'b1; Flags_From_Memory = 3'b101;
    step();
    checks++;
    if ({Flags, EXMEM[75:72]} !== {3'b101, 4'b1011}) begin errors++; $display("FAIL flag_pop got %b/%b exp 101/1011", Flags, EXMEM[75:72]); end
  endtask

  task automatic test_jump();
    // Flags held at NF=1 CF=0 ZF=1 from the pop.
    logic [1:0] fgs_tbl [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       exp_tbl [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    clear_inputs();
    JMP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      FGS = fgs_tbl[i];
      #1;
      checks++;
      if ({Taken_Jump, To_PC_Selector} !== {exp_tbl[i], exp_tbl[i]}) begin
        errors++; $display("FAIL jump_fgs%0d got %b%b exp %b%b", i, Taken_Jump, To_PC_Selector, exp_tbl[i], exp_tbl[i]);
      end
    end
    JMP = 1'b0; JWSP = 1'b1; SPOP = 1'b1;
    #1;
    checks++;
    if ({Taken_Jump, To_PC_Selector} !== 2'b01) begin errors++; $display("FAIL jwsp got %b%b exp 01", Taken_Jump, To_PC_Selector); end
  endtask

  task automatic test_async_reset();
    run_alu(3'd0, 1'b0, 16'd1, 16'd1, 2'b11);
    checks++;
    if (EXMEM[15:0] !== 16'd2) begin errors++; $display("FAIL pre_reset got %0d exp 2", EXMEM[15:0]); end
    reset = 1'b1;
    #1;
    checks++;
    if ({EXMEM, Flags} !== 79'd0) begin errors++; $display("FAIL async_reset got %h/%b exp 0/000", EXMEM, Flags); end
    #1 reset = 1'b0;
    Data1 = 16'd20;
    step();
    checks++;
    if (EXMEM[15:0] !== 16'd21) begin errors++; $display("FAIL post_reset got %0d exp 21", EXMEM[15:0]); end
  endtask

  initial begin
    test_reset();
    test_mov();
    test_arith();
    test_logic();
    test_shift();
    test_incdec_not();
    test_io();
    test_forwarding();
    test_stack();
    test_flag_pop();
    test_jump();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
